// File: rtl/byte8_word32_pkg.sv
// Shared constants, state type and byte-lane helpers for the 8-bit to
// 32-bit word deserializer.
package byte8_word32_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int HELD_W     = (WORD_BYTES - 1) * BYTE_W;
  localparam int CNT_W      = 2;
  localparam int HOLD_W     = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Pushes a byte into the partial-word register. MSB-first shifts left so
  // the oldest byte ends up highest; LSB-first shifts right so it ends up lowest.
  function automatic logic [HELD_W-1:0] shift_byte(
    input logic [HELD_W-1:0] held,
    input logic [BYTE_W-1:0] b,
    input bit                msb_first
  );
    if (msb_first) return {held[HELD_W-BYTE_W-1:0], b};
    else           return {b, held[HELD_W-1:BYTE_W]};
  endfunction

  // Combines the three held bytes with the fourth byte arriving this cycle.
  function automatic logic [WORD_W-1:0] assemble_word(
    input logic [HELD_W-1:0] held,
    input logic [BYTE_W-1:0] last,
    input bit                msb_first
  );
    if (msb_first) return {held, last};
    else           return {last, held};
  endfunction

endpackage

// File: rtl/byte8_word32.sv
// Rebuilds 32-bit words from four consecutive valid bytes on the 8-bit lane,
// holds valid_out for HOLD_CYCLES after each word and flags dropped partials.
module byte8_word32
  import byte8_word32_pkg::*;
#(
  parameter int MSB_FIRST   = 1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] Data_in,
  output logic              valid_out,
  output logic [WORD_W-1:0] Data_out,
  output logic              drop_err
);

  localparam bit                MSB_SEL   = (MSB_FIRST != 0);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORD_BYTES - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [HELD_W-1:0]   held_q;
  logic [HOLD_W-1:0]   hold_q;

  logic                word_done;
  logic                drop;

  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in) state_d = COLLECT;
      end
      COLLECT: begin
        if (!valid_in) begin
          state_d = IDLE;
          drop    = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = IDLE;
          word_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- assembly stage: FSM state, byte count and partial-word register ----
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      if (word_done || !valid_in) begin
        cnt_q  <= '0;
        held_q <= '0;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
        held_q <= shift_byte(held_q, Data_in, MSB_SEL);
      end
    end
  end

  // ---- output stage: word register, valid hold window, drop flag ----
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      Data_out  <= '0;
      valid_out <= 1'b0;
      hold_q    <= '0;
      drop_err  <= 1'b0;
    end else begin
      drop_err <= drop;
      if (word_done) begin
        Data_out  <= assemble_word(held_q, Data_in, MSB_SEL);
        valid_out <= 1'b1;
        hold_q    <= HOLD_LOAD;
      end else if (valid_out) begin
        if (hold_q == '0) valid_out <= 1'b0;
        else              hold_q    <= hold_q - HOLD_W'(1);
      end
    end
  end

endmodule
